// File: rtl/mem_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_sweep_ctrl
//  Purpose  : Sweep sequencer for one inferred block-RAM instance. Owns the
//             address / write-data / write-enable side of the memory and runs
//             one of three end-to-end sweeps:
//               FILL  - write pat(a) to every address 0..DEPTH_MEM-1
//               CHECK - read every address back, count pat(a) mismatches
//               SIGN  - read every address back, accumulate ones-count and
//                       XOR signature (used to confirm bitstream-loaded
//                       content without rewriting the array)
//             pat(a)[i] = a[i mod 32] ^ INVERT
//
//  Ports    : clk            in   clock, all logic on rising edge
//             reset          in   synchronous, active-high reset
//             start          in   one-cycle sweep request (IDLE only)
//             mode[1:0]      in   0=FILL 1=CHECK 2=SIGN 3=reserved (ignored)
//             abort          in   terminate a sweep in progress, no done
//             mem_raddr[31:0] out read address (zero-extended counter)
//             mem_waddr[31:0] out write address (zero-extended counter)
//             mem_din        out  write data, WID_MEM bits
//             mem_we         out  write enable, high only while filling
//             mem_dout       in   registered read data, 1-cycle latency
//             busy           out  sweep in progress (FILL/READ/DRAIN)
//             done           out  one-cycle pulse at normal completion
//             err_count[31:0] out CHECK mismatches, saturating
//             first_err_addr[31:0] out address of first CHECK mismatch
//             ones_count[31:0] out SIGN ones total, saturating
//             xor_sig        out  SIGN XOR of all words read
//
//  Revision : 1.0 - initial release
// ============================================================================
module mem_sweep_ctrl #(
    parameter int WID_MEM   = 1,
    parameter int DEPTH_MEM = 65536,
    parameter int INVERT    = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic               abort,
    output logic [31:0]        mem_raddr,
    output logic [31:0]        mem_waddr,
    output logic [WID_MEM-1:0] mem_din,
    output logic               mem_we,
    input  logic [WID_MEM-1:0] mem_dout,
    output logic               busy,
    output logic               done,
    output logic [31:0]        err_count,
    output logic [31:0]        first_err_addr,
    output logic [31:0]        ones_count,
    output logic [WID_MEM-1:0] xor_sig
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int ADDR_W = $clog2(DEPTH_MEM);
    localparam int CNT_W  = $clog2(WID_MEM + 1);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(DEPTH_MEM - 1);
    localparam logic              c_INV        = (INVERT != 0);
    localparam logic [1:0]        c_MODE_FILL  = 2'd0;
    localparam logic [1:0]        c_MODE_CHECK = 2'd1;
    localparam logic [1:0]        c_MODE_SIGN  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    // Test pattern: bit i of the word is address bit (i mod 32), so words
    // wider than 32 bits repeat the address.
    function automatic logic [WID_MEM-1:0] pattern(input logic [ADDR_W-1:0] a);
        logic [31:0]        a32;
        logic [WID_MEM-1:0] p;
        a32 = 32'(a);
        p   = '0;
        for (int i = 0; i < WID_MEM; i++) begin
            p[i] = a32[i % 32] ^ c_INV;
        end
        return p;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [WID_MEM-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WID_MEM; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state_q,          state_d;
    logic [ADDR_W-1:0]   addr_q,           addr_d;
    logic                sweep_chk_q,      sweep_chk_d;   // 1=CHECK, 0=SIGN
    logic                rd_vld_q,         rd_vld_d;
    logic [ADDR_W-1:0]   rd_tag_q,         rd_tag_d;
    logic [31:0]         err_count_q,      err_count_d;
    logic [31:0]         first_err_addr_q, first_err_addr_d;
    logic [31:0]         ones_count_q,     ones_count_d;
    logic [WID_MEM-1:0]  xor_sig_q,        xor_sig_d;

    logic                w_busy;
    logic                w_mode_ok;
    logic                w_eval;
    logic                w_mismatch;
    logic [WID_MEM-1:0]  w_pat_cur;
    logic [WID_MEM-1:0]  w_pat_tag;
    logic [CNT_W-1:0]    w_pop;
    logic [32:0]         w_ones_sum;

    assign w_busy    = (state_q == ST_FILL) || (state_q == ST_READ) ||
                       (state_q == ST_DRAIN);
    assign w_mode_ok = (mode == c_MODE_FILL) || (mode == c_MODE_CHECK) ||
                       (mode == c_MODE_SIGN);

    assign w_pat_cur  = pattern(addr_q);
    assign w_pat_tag  = pattern(rd_tag_q);
    assign w_pop      = popcount(mem_dout);
    assign w_ones_sum = {1'b0, ones_count_q} + 33'(w_pop);

    // A returning word is evaluated in the cycle after its address was
    // issued. An abort in that same cycle throws the word away.
    assign w_eval     = rd_vld_q && !(abort && w_busy);
    assign w_mismatch = (mem_dout != w_pat_tag);

    // ------------------------------------------------------------------------
    // Next-state and result logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        sweep_chk_d      = sweep_chk_q;
        rd_vld_d         = 1'b0;
        rd_tag_d         = rd_tag_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        ones_count_d     = ones_count_q;
        xor_sig_d        = xor_sig_q;

        // Result accumulation for the word tagged in the previous cycle.
        if (w_eval) begin
            if (sweep_chk_q) begin
                if (w_mismatch) begin
                    if (err_count_q != 32'hFFFF_FFFF) begin
                        err_count_d = err_count_q + 32'd1;
                    end
                    // err_count only leaves zero on the first mismatch of a
                    // sweep, so it doubles as the "first error" marker.
                    if (err_count_q == 32'd0) begin
                        first_err_addr_d = 32'(rd_tag_q);
                    end
                end
            end else begin
                ones_count_d = w_ones_sum[32] ? 32'hFFFF_FFFF : w_ones_sum[31:0];
                xor_sig_d    = xor_sig_q ^ mem_dout;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // abort has no effect here; start with a legal mode wins.
                if (start && w_mode_ok) begin
                    addr_d           = '0;
                    sweep_chk_d      = (mode == c_MODE_CHECK);
                    err_count_d      = '0;
                    first_err_addr_d = 32'hFFFF_FFFF;
                    ones_count_d     = '0;
                    xor_sig_d        = '0;
                    state_d          = (mode == c_MODE_FILL) ? ST_FILL : ST_READ;
                end
            end

            ST_FILL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (addr_q == c_LAST_ADDR) begin
                    // Counter parks on the last address rather than wrapping.
                    state_d = ST_DONE;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end

            ST_READ: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    rd_vld_d = 1'b1;
                    rd_tag_d = addr_q;
                    if (addr_q == c_LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end

            // One extra cycle so the final returned word gets evaluated.
            ST_DRAIN: begin
                state_d = abort ? ST_IDLE : ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            addr_q           <= '0;
            sweep_chk_q      <= 1'b0;
            rd_vld_q         <= 1'b0;
            rd_tag_q         <= '0;
            err_count_q      <= '0;
            first_err_addr_q <= 32'hFFFF_FFFF;
            ones_count_q     <= '0;
            xor_sig_q        <= '0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            sweep_chk_q      <= sweep_chk_d;
            rd_vld_q         <= rd_vld_d;
            rd_tag_q         <= rd_tag_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            ones_count_q     <= ones_count_d;
            xor_sig_q        <= xor_sig_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Memory-side outputs decode straight from registered state, so mem_we
    // falls on the same edge that leaves FILL (abort, completion or reset).
    assign mem_we         = (state_q == ST_FILL);
    assign mem_waddr      = 32'(addr_q);
    assign mem_raddr      = 32'(addr_q);
    assign mem_din        = mem_we ? w_pat_cur : '0;

    assign busy           = w_busy;
    assign done           = (state_q == ST_DONE);
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign ones_count     = ones_count_q;
    assign xor_sig        = xor_sig_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_sweep_ctrl
//  Purpose  : Self-checking bench for mem_sweep_ctrl. Instance A (1-bit x 16,
//             INVERT=0) is compared every cycle against a sweep-phase model;
//             instance B (8-bit x 4, INVERT=1) is checked with literal values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, abort_a, start_b, abort_b;
    logic [1:0]  mode_a, mode_b;

    logic [31:0] a_raddr, a_waddr, a_err, a_first, a_ones;
    logic [0:0]  a_din, a_dout, a_xor;
    logic        a_we, a_busy, a_done;

    logic [31:0] b_raddr, b_waddr, b_err, b_first, b_ones;
    logic [7:0]  b_din, b_dout, b_xor;
    logic        b_we, b_busy, b_done;

    mem_sweep_ctrl #(.WID_MEM(1), .DEPTH_MEM(16), .INVERT(0)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode_a), .abort(abort_a),
        .mem_raddr(a_raddr), .mem_waddr(a_waddr), .mem_din(a_din), .mem_we(a_we),
        .mem_dout(a_dout), .busy(a_busy), .done(a_done), .err_count(a_err),
        .first_err_addr(a_first), .ones_count(a_ones), .xor_sig(a_xor)
    );

    mem_sweep_ctrl #(.WID_MEM(8), .DEPTH_MEM(4), .INVERT(1)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode_b), .abort(abort_b),
        .mem_raddr(b_raddr), .mem_waddr(b_waddr), .mem_din(b_din), .mem_we(b_we),
        .mem_dout(b_dout), .busy(b_busy), .done(b_done), .err_count(b_err),
        .first_err_addr(b_first), .ones_count(b_ones), .xor_sig(b_xor)
    );

    // ------------------------------------------------------------------------
    // Memories (registered read, 1-cycle latency) with a bench poke port
    // ------------------------------------------------------------------------
    logic [15:0] mem_a;
    logic [7:0]  mem_b [4];
    logic        pk_a_en = 1'b0, pk_a_val = 1'b0;
    logic [3:0]  pk_a_addr = '0;
    logic        pk_b_en = 1'b0;
    logic [1:0]  pk_b_addr = '0;
    logic [7:0]  pk_b_val = '0;
    int          cyc = 0;
    int          wr_cnt_a = 0;
    logic [31:0] last_wa = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pk_a_en)   mem_a[pk_a_addr] <= pk_a_val;
        else if (a_we) mem_a[a_waddr[3:0]] <= a_din[0];
        a_dout <= mem_a[a_raddr[3:0]];
        if (a_we) begin
            wr_cnt_a <= wr_cnt_a + 1;
            last_wa  <= a_waddr;
        end
        if (pk_b_en)   mem_b[pk_b_addr] <= pk_b_val;
        else if (b_we) mem_b[b_waddr[1:0]] <= b_din;
        b_dout <= mem_b[b_raddr[1:0]];
    end

    // ------------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        else             n_pass++;
    endtask

    // ------------------------------------------------------------------------
    // Reference model for instance A: a sweep is "sweep step n" cycles after
    // the accepting edge. FILL lasts D steps, CHECK/SIGN D+1; done follows.
    // Result values come from the memory contents seen by the sweep.
    // ------------------------------------------------------------------------
    localparam int D_A = 16;
    int          m_op = 0;      // 0 none, 1 fill, 2 read
    int          m_n = 0, m_len = 0;
    logic        m_chk = 1'b0;
    logic [31:0] e_err = '0, e_first = '1, e_ones = '0;
    logic        e_xor = 1'b0;
    logic        chk_on = 1'b0;

    function automatic logic pat_a(input int a);
        return (a % 2) != 0;
    endfunction

    function automatic logic [31:0] mdl_err();
        int n = 0;
        for (int a = 0; a < D_A; a++) if (mem_a[a] != pat_a(a)) n++;
        return 32'(n);
    endfunction

    function automatic logic [31:0] mdl_first();
        for (int a = 0; a < D_A; a++) if (mem_a[a] != pat_a(a)) return 32'(a);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] mdl_ones();
        int n = 0;
        for (int a = 0; a < D_A; a++) if (mem_a[a]) n++;
        return 32'(n);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_op <= 0; m_n <= 0; m_len <= 0; m_chk <= 1'b0;
            e_err <= '0; e_first <= '1; e_ones <= '0; e_xor <= 1'b0;
        end else if (m_op == 0) begin
            if (start_a && mode_a != 2'd3) begin
                m_op  <= (mode_a == 2'd0) ? 1 : 2;
                m_len <= (mode_a == 2'd0) ? D_A : D_A + 1;
                m_n   <= 1;
                m_chk <= (mode_a == 2'd1);
                e_err <= '0; e_first <= '1; e_ones <= '0; e_xor <= 1'b0;
            end
        end else if (m_n == m_len + 1) begin
            m_op <= 0;
        end else if (abort_a) begin
            m_op <= 0;
        end else begin
            m_n <= m_n + 1;
            if (m_op == 2 && m_n == m_len) begin
                if (m_chk) begin
                    e_err   <= mdl_err();
                    e_first <= mdl_first();
                end else begin
                    e_ones  <= mdl_ones();
                    e_xor   <= ^mem_a;
                end
            end
        end
    end

    logic exp_busy, exp_done, exp_we;
    assign exp_busy = (m_op != 0) && (m_n <= m_len);
    assign exp_done = (m_op != 0) && (m_n == m_len + 1);
    assign exp_we   = (m_op == 1) && (m_n <= m_len);

    always @(negedge clk) begin
        if (chk_on) begin
            check("a_busy", a_busy, exp_busy);
            check("a_done", a_done, exp_done);
            check("a_we",   a_we,   exp_we);
            if (exp_we) begin
                check("a_waddr", a_waddr, 64'(m_n - 1));
                check("a_din",   a_din,   pat_a(m_n - 1));
            end
            if (m_op == 2 && m_n <= D_A) check("a_raddr", a_raddr, 64'(m_n - 1));
            if (m_op == 0 || exp_done) begin
                check("a_err",   a_err,   e_err);
                check("a_first", a_first, e_first);
                check("a_ones",  a_ones,  e_ones);
                check("a_xor",   a_xor,   e_xor);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (called #1 after a rising edge)
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic go(input bit sel, input logic [1:0] m, input logic ab, output int k);
        if (!sel) begin start_a = 1'b1; mode_a = m; abort_a = ab; end
        else      begin start_b = 1'b1; mode_b = m; abort_b = ab; end
        step();
        k = cyc;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output int d);
        bit seen = 1'b0;
        d = -1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if ((sel ? b_done : a_done) == 1'b1) begin
                seen = 1'b1;
                d    = cyc;
            end
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        step();
    endtask

    task automatic poke_a(input int adr, input logic v);
        pk_a_en = 1'b1; pk_a_addr = 4'(adr); pk_a_val = v;
        step();
        pk_a_en = 1'b0;
    endtask

    task automatic poke_b(input int adr, input logic [7:0] v);
        pk_b_en = 1'b1; pk_b_addr = 2'(adr); pk_b_val = v;
        step();
        pk_b_en = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence. cyc during the cycle after accept edge k equals k,
    // so "done in cycle k+17" shows up as d - k == 16.
    // ------------------------------------------------------------------------
    initial begin
        int k, d, w0;
        reset = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; mode_a = 2'd0;
        start_b = 1'b0; abort_b = 1'b0; mode_b = 2'd0;
        step();
        chk_on = 1'b1;
        step();
        check("rst_busy",  a_busy,  64'd0);
        check("rst_we",    a_we,    64'd0);
        check("rst_waddr", a_waddr, 64'd0);
        check("rst_raddr", a_raddr, 64'd0);
        check("rst_din",   a_din,   64'd0);
        check("rst_first", a_first, 64'hFFFF_FFFF);
        check("rst_b_first", b_first, 64'hFFFF_FFFF);
        reset = 1'b0;
        step();

        // FILL, with a stray start (CHECK) during the sweep
        w0 = wr_cnt_a;
        go(1'b0, 2'd0, 1'b0, k);
        repeat (3) step();
        start_a = 1'b1; mode_a = 2'd1;
        step();
        start_a = 1'b0;
        wait_done(1'b0, d);
        check("fill_done_cyc", 64'(d - k), 64'd16);
        check("fill_wr_cnt",   64'(wr_cnt_a - w0), 64'd16);
        check("fill_mem",      mem_a, 64'hAAAA);

        // reserved mode is ignored
        start_a = 1'b1; mode_a = 2'd3;
        step();
        start_a = 1'b0;
        check("mode3_busy", a_busy, 64'd0);

        // CHECK with abort in the same IDLE cycle as start
        w0 = wr_cnt_a;
        go(1'b0, 2'd1, 1'b1, k);
        wait_done(1'b0, d);
        check("chk_done_cyc", 64'(d - k), 64'd17);
        check("chk_err",      a_err,   64'd0);
        check("chk_first",    a_first, 64'hFFFF_FFFF);
        check("chk_no_write", 64'(wr_cnt_a - w0), 64'd0);

        // corrupt words 5 and 9, then CHECK
        poke_a(5, 1'b0);
        poke_a(9, 1'b0);
        go(1'b0, 2'd1, 1'b0, k);
        wait_done(1'b0, d);
        check("corrupt_err",   a_err,   64'd2);
        check("corrupt_first", a_first, 64'd5);

        // SIGN over 0xA88A: six ones, even parity
        go(1'b0, 2'd2, 1'b0, k);
        wait_done(1'b0, d);
        check("a_sign_ones", a_ones, 64'd6);
        check("a_sign_xor",  a_xor,  64'd0);

        // FILL aborted in cycle k+6
        w0 = wr_cnt_a;
        go(1'b0, 2'd0, 1'b0, k);
        repeat (5) step();
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check("abort_busy", a_busy, 64'd0);
        repeat (20) step();
        check("abort_wr_cnt",  64'(wr_cnt_a - w0), 64'd6);
        check("abort_last_wa", last_wa, 64'd5);
        check("abort_mem",     mem_a,   64'hA8AA);

        // reset during READ in cycle k+4, then a normal CHECK
        go(1'b0, 2'd1, 1'b0, k);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_busy",  a_busy,  64'd0);
        check("mid_rst_raddr", a_raddr, 64'd0);
        check("mid_rst_first", a_first, 64'hFFFF_FFFF);
        go(1'b0, 2'd1, 1'b0, k);
        wait_done(1'b0, d);
        check("post_rst_done_cyc", 64'(d - k), 64'd17);
        check("post_rst_err",      a_err,   64'd1);
        check("post_rst_first",    a_first, 64'd9);

        // Instance B: SIGN over preloaded 01,03,07,0F
        poke_b(0, 8'h01); poke_b(1, 8'h03); poke_b(2, 8'h07); poke_b(3, 8'h0F);
        go(1'b1, 2'd2, 1'b0, k);
        wait_done(1'b1, d);
        check("b_sign_done_cyc", 64'(d - k), 64'd5);
        check("b_sign_ones",     b_ones, 64'd10);
        check("b_sign_xor",      b_xor,  64'h0A);

        // Instance B: FILL with inverted pattern FF,FE,FD,FC
        go(1'b1, 2'd0, 1'b0, k);
        wait_done(1'b1, d);
        check("b_fill_done_cyc", 64'(d - k), 64'd4);
        check("b_fill_mem", {mem_b[0], mem_b[1], mem_b[2], mem_b[3]}, 64'hFFFEFDFC);
        go(1'b1, 2'd2, 1'b0, k);
        wait_done(1'b1, d);
        check("b_fill_ones", b_ones, 64'd28);
        check("b_fill_xor",  b_xor,  64'h00);
        go(1'b1, 2'd1, 1'b0, k);
        wait_done(1'b1, d);
        check("b_chk_err",   b_err,   64'd0);
        check("b_chk_first", b_first, 64'hFFFF_FFFF);
        poke_b(2, 8'h00);
        go(1'b1, 2'd1, 1'b0, k);
        wait_done(1'b1, d);
        check("b_bad_err",   b_err,   64'd1);
        check("b_bad_first", b_first, 64'd2);
        check("b_idle_busy", b_busy,  64'd0);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
